// File: rtl/fnd_uart_sender.sv
// Formats an SR04 distance or DHT11 reading as a 14-byte ASCII line and sends it over UART (8N1).
// Define FND_UART_PARITY_EN to add an even-parity bit after data bit 7 (8E1 frames).
module fnd_uart_sender #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send_trig,
    input  logic [2:0]  sel_sw,
    input  logic [15:0] uart_send_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BIT_CLKS = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
`ifdef FND_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(FRAME_BITS - 1);
    localparam logic [3:0]       IDX_LAST  = 4'd13;
    localparam logic [2:0]       SEL_SR04  = 3'b010;
    localparam logic [2:0]       SEL_DHT11 = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [2:0]       sel_q;
    logic [15:0]      data_q;
    logic [3:0]       idx;
    logic [7:0]       load_byte;
    logic [7:0]       tx_byte;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] clk_cnt;
    logic             accept;
    logic             byte_end;

    function automatic logic [7:0] digit_char(input logic [3:0] v);
        return (v <= 4'd9) ? (8'h30 + {4'h0, v}) : 8'h3F;
    endfunction

    function automatic logic [7:0] msg_byte(
        input logic [2:0]  sel,
        input logic [15:0] data,
        input logic [3:0]  pos
    );
        logic [7:0] c;
        c = 8'h0A;
        if (sel == SEL_DHT11) begin
            case (pos)
                4'd0:    c = 8'h52;
                4'd1:    c = 8'h48;
                4'd2:    c = 8'h3A;
                4'd3:    c = digit_char(data[15:12]);
                4'd4:    c = digit_char(data[11:8]);
                4'd5:    c = 8'h25;
                4'd6:    c = 8'h20;
                4'd7:    c = 8'h54;
                4'd8:    c = 8'h3A;
                4'd9:    c = digit_char(data[7:4]);
                4'd10:   c = digit_char(data[3:0]);
                4'd11:   c = 8'h43;
                4'd12:   c = 8'h0D;
                default: c = 8'h0A;
            endcase
        end else begin
            case (pos)
                4'd0:    c = 8'h44;
                4'd1:    c = 8'h49;
                4'd2:    c = 8'h53;
                4'd3:    c = 8'h54;
                4'd4:    c = 8'h3A;
                4'd5:    c = digit_char(data[15:12]);
                4'd6:    c = digit_char(data[11:8]);
                4'd7:    c = digit_char(data[7:4]);
                4'd8:    c = 8'h2E;
                4'd9:    c = digit_char(data[3:0]);
                4'd10:   c = 8'h63;
                4'd11:   c = 8'h6D;
                4'd12:   c = 8'h0D;
                default: c = 8'h0A;
            endcase
        end
        return c;
    endfunction

    // Line level for frame position pos: start, data LSB first, [parity], stop.
    function automatic logic frame_bit(input logic [3:0] pos, input logic [7:0] b);
        logic v;
        v = 1'b1;
        if (pos == 4'd0)
            v = 1'b0;
        else if (pos <= 4'd8)
            v = b[3'(pos - 4'd1)];
`ifdef FND_UART_PARITY_EN
        else if (pos == 4'd9)
            v = ^b;
`endif
        return v;
    endfunction

    assign accept   = (state == IDLE) && send_trig &&
                      ((sel_sw == SEL_SR04) || (sel_sw == SEL_DHT11));
    assign byte_end = busy && (clk_cnt == CNT_LAST) && (bit_cnt == BIT_LAST);

    // The start bit is launched on acceptance and at each stop-bit end, so LOAD and SEND
    // run inside the start bit; tx_byte is needed only when data bit 0 begins (BIT_CLKS >= 3).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            sel_q     <= '0;
            data_q    <= '0;
            idx       <= '0;
            load_byte <= '0;
            tx_byte   <= '0;
            bit_cnt   <= '0;
            clk_cnt   <= '0;
        end else begin
            done <= 1'b0;

            if (busy) begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt <= '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (idx == IDX_LAST) begin
                            busy <= 1'b0;
                            tx   <= 1'b1;
                        end else begin
                            tx <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        tx      <= frame_bit(bit_cnt + 4'd1, tx_byte);
                    end
                end else begin
                    clk_cnt <= clk_cnt + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        sel_q   <= sel_sw;
                        data_q  <= uart_send_data;
                        idx     <= '0;
                        busy    <= 1'b1;
                        tx      <= 1'b0;
                        bit_cnt <= '0;
                        clk_cnt <= '0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    load_byte <= msg_byte(sel_q, data_q, idx);
                    state     <= SEND;
                end
                SEND: begin
                    tx_byte <= load_byte;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (byte_end) begin
                        if (idx < IDX_LAST) begin
                            idx   <= idx + 4'd1;
                            state <= LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fnd_uart_sender.sv
// Testbench for fnd_uart_sender: table vectors, random messages and multi-cycle corner cases
// checked cycle-by-cycle against a string-level model of the expected serial line.
`timescale 1ns/1ps
module tb_fnd_uart_sender;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int BIT_CLKS = 16;
`ifdef FND_UART_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int MSG_CLKS = 14 * FRAME * BIT_CLKS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        send_trig = 1'b0;
    logic [2:0]  sel_sw = 3'b000;
    logic [15:0] uart_send_data = 16'h0000;
    logic        tx;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [15:0] data;
        bit          accept;
        string       msg;
        int          idle_len;
    } vec_t;

    vec_t vq[$];

    fnd_uart_sender #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk),
        .reset(reset),
        .send_trig(send_trig),
        .sel_sw(sel_sw),
        .uart_send_data(uart_send_data),
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic string show(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s.getc(i) < 8'h20) r = $sformatf("%s<%02h>", r, s.getc(i));
            else                   r = $sformatf("%s%c", r, s.getc(i));
        end
        return r;
    endfunction

    task automatic chk_s(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, show(act), show(exp));
        end
    endtask

    function automatic string ch(input logic [3:0] v);
        return $sformatf("%c", (v < 4'd10) ? (8'd48 + {4'd0, v}) : 8'd63);
    endfunction

    function automatic string model_msg(input logic [2:0] sel, input logic [15:0] d);
        if (sel == 3'b100)
            return {"RH:", ch(d[15:12]), ch(d[11:8]), "% T:", ch(d[7:4]), ch(d[3:0]), "C\015\012"};
        return {"DIST:", ch(d[15:12]), ch(d[11:8]), ch(d[7:4]), ".", ch(d[3:0]), "cm\015\012"};
    endfunction

    // Expected line level k clocks after the first start bit began.
    function automatic logic model_tx(input string m, input int k);
        int         b;
        int         pos;
        logic [7:0] c;
        b   = k / (FRAME * BIT_CLKS);
        pos = (k / BIT_CLKS) % FRAME;
        c   = m.getc(b);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return c[3'(pos - 1)];
        if (pos == 9 && FRAME == 11) return ^c;
        return 1'b1;
    endfunction

    task automatic add(input string n, input logic [2:0] s, input logic [15:0] d,
                       input bit a, input string m, input int il);
        vec_t v;
        v.name = n; v.sel = s; v.data = d; v.accept = a; v.msg = m; v.idle_len = il;
        vq.push_back(v);
    endtask

    task automatic trig(input logic [2:0] s, input logic [15:0] d);
        sel_sw = s;
        uart_send_data = d;
        send_trig = 1'b1;
        step;
        send_trig = 1'b0;
    endtask

    // Called just after the acceptance edge; walks stop_at clocks of the message.
    task automatic check_msg(input string name, input string exp, input bit perturb, input int stop_at);
        int         tx_err;
        int         busy_hi;
        int         done_hi;
        int         pos;
        logic [7:0] rxb;
        string      got;
        tx_err = 0; busy_hi = 0; done_hi = 0; rxb = 8'h00; got = "";
        for (int k = 0; k < stop_at; k++) begin
            if (tx !== model_tx(exp, k)) tx_err++;
            if (busy === 1'b1) busy_hi++;
            if (done !== 1'b0) done_hi++;
            pos = (k / BIT_CLKS) % FRAME;
            if (k % BIT_CLKS == BIT_CLKS / 2 && pos >= 1 && pos <= 8) begin
                rxb[3'(pos - 1)] = tx;
                if (pos == 8) got = $sformatf("%s%c", got, rxb);
            end
            send_trig = perturb && (k == 100 || k == 500);
            if (perturb && k == 300) begin
                uart_send_data = 16'hFFFF;
                sel_sw = (sel_sw == 3'b010) ? 3'b100 : 3'b010;
            end
            step;
        end
        send_trig = 1'b0;
        chk({name, "_tx_wave_errs"}, tx_err, 0);
        chk({name, "_busy_clks"}, busy_hi, stop_at);
        chk({name, "_early_done"}, done_hi, 0);
        if (stop_at == MSG_CLKS) begin
            chk_s({name, "_text"}, got, exp);
            chk({name, "_done_end"}, int'(done), 1);
            chk({name, "_busy_end"}, int'(busy), 0);
            chk({name, "_tx_end"}, int'(tx), 1);
        end
    endtask

    task automatic check_idle(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            step;
        end
        chk({name, "_idle_errs"}, bad, 0);
    endtask

    initial begin
        string       m;
        logic [2:0]  rs;
        logic [15:0] rd;

        add("sr04_1234", 3'b010, 16'h1234, 1'b1, "DIST:123.4cm\015\012", 0);
        add("dht_5627",  3'b100, 16'h5627, 1'b1, "RH:56% T:27C\015\012", 0);
        add("sel_001",   3'b001, 16'h1234, 1'b0, "", 3000);
        add("sel_000",   3'b000, 16'h1234, 1'b0, "", 3000);
        add("sr04_1a34", 3'b010, 16'h1A34, 1'b1, "DIST:1?3.4cm\015\012", 0);
        add("sel_111",   3'b111, 16'h4444, 1'b0, "", 300);
        add("sel_110",   3'b110, 16'h4444, 1'b0, "", 300);
        add("sr04_9f0c", 3'b010, 16'h9F0C, 1'b1, "DIST:9?0.?cm\015\012", 0);
        add("dht_fa09",  3'b100, 16'hFA09, 1'b1, "RH:??% T:09C\015\012", 0);

        repeat (3) step;
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        step;

        foreach (vq[i]) begin
            trig(vq[i].sel, vq[i].data);
            if (vq[i].accept) begin
                check_msg(vq[i].name, vq[i].msg, 1'b1, MSG_CLKS);
                step;
                check_idle({vq[i].name, "_after"}, 20);
            end else begin
                check_idle(vq[i].name, vq[i].idle_len);
            end
        end

        for (int i = 0; i < 4; i++) begin
            rs = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b100;
            rd = 16'($urandom);
            m = model_msg(rs, rd);
            trig(rs, rd);
            check_msg($sformatf("rand%0d", i), m, 1'b1, MSG_CLKS);
            step;
            check_idle($sformatf("rand%0d_after", i), 20);
        end

        // Trigger presented on the done cycle must be dropped.
        trig(3'b010, 16'h0987);
        check_msg("done_cyc", model_msg(3'b010, 16'h0987), 1'b0, MSG_CLKS);
        send_trig = 1'b1;
        step;
        send_trig = 1'b0;
        check_idle("done_cyc_trig", 200);

        // Trigger presented on the cycle after done must start a new message.
        trig(3'b100, 16'h3141);
        check_msg("next_a", model_msg(3'b100, 16'h3141), 1'b0, MSG_CLKS);
        step;
        trig(3'b010, 16'h2718);
        check_msg("next_b", model_msg(3'b010, 16'h2718), 1'b0, MSG_CLKS);
        step;
        check_idle("next_b_after", 20);

        // Reset in the middle of a frame.
        trig(3'b100, 16'h8765);
        check_msg("pre_rst", model_msg(3'b100, 16'h8765), 1'b0, 700);
        #2 reset = 1'b1;
        #1;
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle("post_rst", 300);
        trig(3'b010, 16'h4321);
        check_msg("post_rst_msg", model_msg(3'b010, 16'h4321), 1'b0, MSG_CLKS);
        step;
        check_idle("post_rst_after", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fnd_uart_sender.md
FND_UART_SENDER -- requirements
Module: fnd_uart_sender

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning UART bit rate; BIT_CLKS = CLK_FREQ/BAUD, integer division (10416 at defaults).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port send_trig, input, 1 bit: single-cycle request to transmit one message.
REQ-006 The block SHALL have port sel_sw, input, 3 bits: source select; 3'b010 selects SR04, 3'b100 selects DHT11, and any other value selects none.
REQ-007 The block SHALL have port uart_send_data, input, 16 bits: four BCD digits, [15:12] first through [3:0] last.
REQ-008 The block SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a message is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse when a message completes.

Function
REQ-011 The block SHALL accept send_trig only when busy=0 and sel_sw is 3'b010 or 3'b100; in the same edge it SHALL latch sel_sw and uart_send_data.
REQ-012 The block SHALL ignore send_trig while busy=1 and with any other sel_sw value, and SHALL produce no pulse, no tx activity and no queueing for it.
REQ-013 busy SHALL go high on the cycle after acceptance, and the start bit SHALL begin on that same cycle.
REQ-014 Latched data SHALL be used for the whole message; input changes mid-message SHALL have no effect.
REQ-015 SR04 message, with digits d3..d0: "DIST:" d3 d2 d1 "." d0 "cm" CR LF, which is 14 bytes.
REQ-016 DHT11 message, with digits h1 h0 t1 t0: "RH:" h1 h0 "%" " T:" t1 t0 "C" CR LF, which is 14 bytes.
REQ-017 A digit value of 0-9 SHALL be sent as ASCII 0x30+value; a value of 10-15 SHALL be sent as '?' (0x3F).
REQ-018 The formatter FSM SHALL have states IDLE, LOAD, SEND, WAIT and DONE.
REQ-019 FSM transitions: IDLE->LOAD on acceptance; LOAD selects the byte at the current index.
REQ-020 FSM transitions: SEND starts the byte-serializer; WAIT holds until the serializer finishes.
REQ-021 FSM transitions: from WAIT, go to LOAD (index+1) if index<13, else to DONE; DONE always returns to IDLE.
REQ-022 The byte-serializer frame SHALL be 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1); each bit SHALL last exactly BIT_CLKS clocks.
REQ-023 Consecutive bytes SHALL be sent back-to-back with no idle time between one stop bit and the next start bit.
REQ-024 A message SHALL occupy exactly 14 x 10 x BIT_CLKS clocks on tx, measured from the start of the first start bit to the end of the last stop bit.
REQ-025 done SHALL pulse high for 1 cycle on the first clock after the last stop bit ends, and busy SHALL fall on that same cycle.
REQ-026 A send_trig arriving on the done cycle SHALL be ignored; a send_trig arriving on the next cycle SHALL be accepted.
REQ-027 The bit counter and the bit-period counter SHALL wrap to 0 at the end of every bit and every byte; they SHALL never free-run while the FSM is in IDLE.

Reset
REQ-028 Asserting reset SHALL force, immediately and asynchronously, tx=1, busy=0, done=0, FSM=IDLE, and all counters, the index and the latched data to 0.
REQ-029 A reset asserted mid-frame SHALL abort the message, leaving tx high with no partial-byte completion; after release, the block SHALL wait for a new send_trig.

Configuration
REQ-030 With macro FND_UART_PARITY_EN defined, each frame SHALL carry an even-parity bit after data bit 7, making the frame 11 bits and the message 14 x 11 x BIT_CLKS clocks.
REQ-031 With FND_UART_PARITY_EN undefined, no parity logic SHALL exist, and the frame SHALL be 10 bits as in REQ-022.

Verification (CLK_FREQ=16, BAUD=1, so BIT_CLKS=16; parity off unless stated)
REQ-032 Case 1: sel_sw=3'b010, data=16'h1234, pulse send_trig -> tx decodes "DIST:123.4cm\r\n"; busy is high for 2240 clocks; done pulses once.
REQ-033 Case 2: sel_sw=3'b100, data=16'h5627 -> tx decodes "RH:56% T:27C\r\n"; each byte's start bit falls exactly 160 clocks after the previous one.
REQ-034 Case 3: sel_sw=3'b001 or 3'b000 with send_trig -> tx stays 1, busy stays 0, no done pulse, for 3000 clocks.
REQ-035 Case 4: send_trig pulsed at clocks 100 and 500 of a message, with uart_send_data changed to 16'hFFFF at clock 300 -> a single message with the original digits; done pulses once.
REQ-036 Case 5: data=16'h1A34 on SR04 -> "DIST:1?3.4cm\r\n"; separately, reset at clock 700 of a message -> tx=1 and busy=0 within the reset cycle; a new trigger afterwards yields a complete, correct message.
REQ-037 Case 6: FND_UART_PARITY_EN defined, byte '1' (0x31, three ones) -> parity bit 1; busy is high for 2464 clocks per message.
